styler_host: RTL and testbench

Host-side bus master for the text-attribute styler: accepts one glyph-row render request (scanline, control, 16-bit bitmap, 25-bit attribute word), sequences it into the styler's register-write interface one byte at a time, then reads back the styled bitmap and output scanline. It sits between a character-cell fetch engine and the styler macro's `ui_in`/`uio`/`uo_out` pins. It owns bus direction and write strobing, so the fetch engine only sees a valid/ready request and response pair.

---
 rtl/styler_host.sv | 244 ++++++++++++++++++++++++
 tb/tb_styler_host.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/styler_host.sv
// Host bus master for the text-attribute styler: byte-serial register writes, then bitmap/scanline readback.
// Optional STYLER_HOST_DIFF_EN keeps a shadow of written bytes and skips writes that would not change them.
module styler_host #(
    parameter int unsigned READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_scanline,
    input  logic [5:0]  req_ctrl,
    input  logic [15:0] req_bitmap,
    input  logic [24:0] req_attr,
    input  logic        faint_phase,
    input  logic        blink_phase,
    input  logic        cursor_phase,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_bitmap,
    output logic [3:0]  rsp_scanline,
    output logic [7:0]  st_ui,
    output logic [7:0]  st_uio_out,
    output logic        st_uio_oe,
    input  logic [7:0]  st_uo
);
    localparam int unsigned NB     = 8;
    localparam int unsigned BUS_W  = 8 * NB;
    localparam int unsigned RCNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_HOLD,
        S_TURN,
        S_READ,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [BUS_W-1:0]    wr_bytes_q, wr_bytes_d;
    logic [NB-1:0]       wr_mask_q, wr_mask_d;
    logic [2:0]          wr_idx_q, wr_idx_d;
    logic [1:0]          rd_sel_q, rd_sel_d;
    logic [RCNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [15:0]         rsp_bitmap_q, rsp_bitmap_d;
    logic [3:0]          rsp_scanline_q, rsp_scanline_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                req_ready_q, req_ready_d;
    logic                ui_we_n_q, ui_we_n_d;
    logic [2:0]          ui_addr_q, ui_addr_d;
    logic [7:0]          uio_out_q, uio_out_d;
    logic                uio_oe_q, uio_oe_d;

    logic [BUS_W-1:0]    req_bytes;
    logic [NB-1:0]       wr_list;
    logic [NB-1:0]       mask_rem;
    logic                accept;

`ifdef STYLER_HOST_DIFF_EN
    logic [BUS_W-1:0]    shadow_q, shadow_d;
    logic [NB-1:0]       shadow_vld_q, shadow_vld_d;
`endif

    // Lowest pending index, so writes go out in ascending address order.
    function automatic logic [2:0] first_set(input logic [NB-1:0] m);
        first_set = 3'd0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (m[i]) first_set = 3'(i);
        end
    endfunction

    function automatic logic [2:0] rd_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    rd_addr = 3'd2;
            2'd1:    rd_addr = 3'd3;
            default: rd_addr = 3'd0;
        endcase
    endfunction

    // Request fields laid out in styler write-address order, byte i at bits [8i+7:8i].
    always_comb begin
        req_bytes = {7'd0, req_attr[24], req_attr[23:0], req_bitmap,
                     2'd0, req_ctrl, 4'd0, req_scanline};
`ifdef STYLER_HOST_DIFF_EN
        wr_list = '0;
        for (int i = 0; i < NB; i++) begin
            wr_list[i] = ~shadow_vld_q[i] | (shadow_q[8*i +: 8] != req_bytes[8*i +: 8]);
        end
`else
        wr_list = '1;
`endif
    end

    assign accept = req_valid & req_ready_q;

    // Next-state and sequencing.
    always_comb begin
        state_d        = state_q;
        wr_bytes_d     = wr_bytes_q;
        wr_mask_d      = wr_mask_q;
        wr_idx_d       = wr_idx_q;
        rd_sel_d       = rd_sel_q;
        rd_cnt_d       = rd_cnt_q;
        rsp_bitmap_d   = rsp_bitmap_q;
        rsp_scanline_d = rsp_scanline_q;
        mask_rem       = wr_mask_q & ~(8'd1 << wr_idx_q);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_bytes_d = req_bytes;
                    wr_mask_d  = wr_list;
                    if (|wr_list) begin
                        state_d  = S_WR_SETUP;
                        wr_idx_d = first_set(wr_list);
                    end else begin
                        state_d = S_TURN;
                    end
                end
            end
            S_WR_SETUP: state_d = S_WR_HOLD;
            S_WR_HOLD: begin
                wr_mask_d = mask_rem;
                if (|mask_rem) begin
                    state_d  = S_WR_SETUP;
                    wr_idx_d = first_set(mask_rem);
                end else begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                state_d  = S_READ;
                rd_sel_d = 2'd0;
                rd_cnt_d = '0;
            end
            S_READ: begin
                if (rd_cnt_q == RCNT_W'(READ_WAIT)) begin
                    rd_cnt_d = '0;
                    rd_sel_d = 2'(rd_sel_q + 2'd1);
                    case (rd_sel_q)
                        2'd0:    rsp_bitmap_d[7:0]  = st_uo;
                        2'd1:    rsp_bitmap_d[15:8] = st_uo;
                        default: begin
                            rsp_scanline_d = st_uo[3:0];
                            state_d        = S_RESP;
                        end
                    endcase
                end else begin
                    rd_cnt_d = RCNT_W'(rd_cnt_q + 1'b1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin values decoded from the upcoming state so they register in step with it.
    always_comb begin
        ui_we_n_d   = 1'b1;
        ui_addr_d   = 3'd0;
        uio_out_d   = 8'd0;
        uio_oe_d    = 1'b0;
        rsp_valid_d = (state_d == S_RESP);
        req_ready_d = (state_d == S_IDLE);
        case (state_d)
            S_WR_SETUP, S_WR_HOLD: begin
                ui_we_n_d = (state_d == S_WR_HOLD);
                ui_addr_d = wr_idx_d;
                uio_out_d = wr_bytes_d[{wr_idx_d, 3'b000} +: 8];
                uio_oe_d  = 1'b1;
            end
            S_READ:  ui_addr_d = rd_addr(rd_sel_d);
            default: ui_addr_d = 3'd0;
        endcase
    end

`ifdef STYLER_HOST_DIFF_EN
    // Shadow tracks what the styler latches hold; a byte counts as written once its hold cycle ends.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        if (state_q == S_WR_HOLD) begin
            shadow_d[{wr_idx_q, 3'b000} +: 8] = wr_bytes_q[{wr_idx_q, 3'b000} +: 8];
            shadow_vld_d[wr_idx_q]            = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            shadow_vld_q <= '0;
        end else begin
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_bytes_q     <= '0;
            wr_mask_q      <= '0;
            wr_idx_q       <= 3'd0;
            rd_sel_q       <= 2'd0;
            rd_cnt_q       <= '0;
            rsp_bitmap_q   <= 16'd0;
            rsp_scanline_q <= 4'd0;
            rsp_valid_q    <= 1'b0;
            req_ready_q    <= 1'b0;
            ui_we_n_q      <= 1'b1;
            ui_addr_q      <= 3'd0;
            uio_out_q      <= 8'd0;
            uio_oe_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_bytes_q     <= wr_bytes_d;
            wr_mask_q      <= wr_mask_d;
            wr_idx_q       <= wr_idx_d;
            rd_sel_q       <= rd_sel_d;
            rd_cnt_q       <= rd_cnt_d;
            rsp_bitmap_q   <= rsp_bitmap_d;
            rsp_scanline_q <= rsp_scanline_d;
            rsp_valid_q    <= rsp_valid_d;
            req_ready_q    <= req_ready_d;
            ui_we_n_q      <= ui_we_n_d;
            ui_addr_q      <= ui_addr_d;
            uio_out_q      <= uio_out_d;
            uio_oe_q       <= uio_oe_d;
        end
    end

    // Output disable shares the drive-enable flop, so host and styler can never both drive uio.
    assign st_ui        = {ui_we_n_q, uio_oe_q, cursor_phase, blink_phase, faint_phase, ui_addr_q};
    assign st_uio_out   = uio_out_q;
    assign st_uio_oe    = uio_oe_q;
    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_bitmap   = rsp_bitmap_q;
    assign rsp_scanline = rsp_scanline_q;

endmodule

// File: tb/tb_styler_host.sv
// Directed bench for styler_host with a small styler register model on the uio/uo pins.
// Latency and write-count expectations switch with STYLER_HOST_DIFF_EN.
module tb_styler_host;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid3;
    logic        req_ready, req_ready3;
    logic [3:0]  req_scanline;
    logic [5:0]  req_ctrl;
    logic [15:0] req_bitmap;
    logic [24:0] req_attr;
    logic        faint_phase, blink_phase, cursor_phase;
    logic        rsp_valid, rsp_valid3;
    logic        rsp_ready, rsp_ready3;
    logic [15:0] rsp_bitmap, rsp_bitmap3;
    logic [3:0]  rsp_scanline, rsp_scanline3;
    logic [7:0]  st_ui, st_ui3;
    logic [7:0]  st_uio_out, st_uio_out3;
    logic        st_uio_oe, st_uio_oe3;
    logic [7:0]  st_uo, st_uo3;

    logic [63:0] sreg0, sreg3;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          bus_viol = 0;
    int          ph_viol = 0;
    int          last_wr_cyc = -1;
    int          first_rd_cyc = -1;
    logic [7:0]  wa_log[$];
    logic [7:0]  wd_log[$];

    always #5 clk = ~clk;

    styler_host #(.READ_WAIT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_scanline(req_scanline), .req_ctrl(req_ctrl), .req_bitmap(req_bitmap), .req_attr(req_attr),
        .faint_phase(faint_phase), .blink_phase(blink_phase), .cursor_phase(cursor_phase),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bitmap(rsp_bitmap), .rsp_scanline(rsp_scanline),
        .st_ui(st_ui), .st_uio_out(st_uio_out), .st_uio_oe(st_uio_oe), .st_uo(st_uo)
    );

    styler_host #(.READ_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_scanline(req_scanline), .req_ctrl(req_ctrl), .req_bitmap(req_bitmap), .req_attr(req_attr),
        .faint_phase(faint_phase), .blink_phase(blink_phase), .cursor_phase(cursor_phase),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_bitmap(rsp_bitmap3), .rsp_scanline(rsp_scanline3),
        .st_ui(st_ui3), .st_uio_out(st_uio_out3), .st_uio_oe(st_uio_oe3), .st_uo(st_uo3)
    );

    // Styler stand-in: bitmap ^ attr[15:0], inverted when ctrl[0]; scanline + 1; one cycle to settle.
    function automatic logic [7:0] styl_out(input logic [7:0] ui, input logic [63:0] r);
        logic [15:0] bm;
        logic [3:0]  sl;
        bm = r[31:16] ^ r[47:32];
        if (r[8]) bm = ~bm;
        sl = 4'(r[3:0] + 4'd1);
        if (ui[6]) return 8'h00;
        case (ui[2:0])
            3'd0:    return {sl, sl};
            3'd2:    return bm[7:0];
            3'd3:    return bm[15:8];
            default: return 8'hA5;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!st_ui[7] && st_uio_oe) sreg0[{st_ui[2:0], 3'b000} +: 8] <= st_uio_out;
        if (!st_ui3[7] && st_uio_oe3) sreg3[{st_ui3[2:0], 3'b000} +: 8] <= st_uio_out3;
        st_uo  <= styl_out(st_ui, sreg0);
        st_uo3 <= styl_out(st_ui3, sreg3);
    end

    always @(negedge clk) begin
        if (st_uio_oe !== st_ui[6]) bus_viol++;
        if (st_uio_oe3 !== st_ui3[6]) bus_viol++;
        if (st_ui[5:3] !== 3'b011) ph_viol++;
        if (st_uio_oe) last_wr_cyc = cyc;
        if (!st_ui[7] && st_uio_oe) begin
            wa_log.push_back({5'd0, st_ui[2:0]});
            wd_log.push_back(st_uio_out);
        end
        if (!st_uio_oe && st_ui[2:0] == 3'd2 && first_rd_cyc < 0) first_rd_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = cycle index of first rsp_valid, counting the accept cycle as 0.
    task automatic do_req(input logic [3:0] sl, input logic [5:0] c, input logic [15:0] bm,
                          input logic [24:0] at, output int lat);
        check("req_ready_pre", 32'(req_ready), 32'd1);
        req_scanline = sl;
        req_ctrl     = c;
        req_bitmap   = bm;
        req_attr     = at;
        req_valid    = 1'b1;
        wa_log.delete();
        wd_log.delete();
        last_wr_cyc  = -1;
        first_rd_cyc = -1;
        tick();
        req_valid    = 1'b0;
        req_scanline = ~sl;
        req_ctrl     = ~c;
        req_bitmap   = ~bm;
        req_attr     = ~at;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic check_writes(input logic [63:0] bytes);
        check("wr_count", 32'(wa_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wr_addr%0d", i), 32'(wa_log[i]), 32'(i));
            check($sformatf("wr_data%0d", i), 32'(wd_log[i]), 32'(bytes[8*i +: 8]));
        end
    endtask

    initial begin
        int          lat;
        int          hold_bad;
        logic [63:0] a_bytes;
        a_bytes      = 64'h00_00_00_00_12_34_00_05;
        sreg0        = '0;
        sreg3        = '0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_valid3   = 1'b0;
        rsp_ready    = 1'b0;
        rsp_ready3   = 1'b0;
        req_scanline = 4'd0;
        req_ctrl     = 6'd0;
        req_bitmap   = 16'd0;
        req_attr     = 25'd0;
        faint_phase  = 1'b1;
        blink_phase  = 1'b1;
        cursor_phase = 1'b0;

        repeat (3) tick();
        check("rst_st_ui", 32'(st_ui), 32'h98);
        check("rst_oe", 32'(st_uio_oe), 32'd0);
        check("rst_uio_out", 32'(st_uio_out), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_bitmap", 32'(rsp_bitmap), 32'd0);
        check("rst_rsp_scanline", 32'(rsp_scanline), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Request A: full write list on a cold shadow.
        do_req(4'd5, 6'h00, 16'h1234, 25'h0, lat);
        check("a_latency", 32'(lat), 32'd24);
        check_writes(a_bytes);
        check("a_bitmap", 32'(rsp_bitmap), 32'h1234);
        check("a_scanline", 32'(rsp_scanline), 32'h6);
        check("a_turn_gap", 32'(first_rd_cyc - last_wr_cyc), 32'd2);

        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || st_ui[7] !== 1'b1 ||
                rsp_bitmap !== 16'h1234 || rsp_scanline !== 4'h6) hold_bad++;
        end
        check("a_hold_cycles_bad", 32'(hold_bad), 32'd0);
        ack();
        check("a_bitmap_kept", 32'(rsp_bitmap), 32'h1234);
        check("a_scanline_kept", 32'(rsp_scanline), 32'h6);

        // Request B: invert path and scanline wrap; byte 6 matches A.
        do_req(4'hF, 6'h01, 16'hA5C3, 25'h1003C0F, lat);
`ifdef STYLER_HOST_DIFF_EN
        check("b_latency", 32'(lat), 32'd22);
        check("b_wr_count", 32'(wa_log.size()), 32'd7);
`else
        check("b_latency", 32'(lat), 32'd24);
        check("b_wr_count", 32'(wa_log.size()), 32'd8);
`endif
        check("b_bitmap", 32'(rsp_bitmap), 32'h6633);
        check("b_scanline", 32'(rsp_scanline), 32'h0);
        ack();

        // Identical repeat of B.
        do_req(4'hF, 6'h01, 16'hA5C3, 25'h1003C0F, lat);
`ifdef STYLER_HOST_DIFF_EN
        check("b2_latency", 32'(lat), 32'd8);
        check("b2_wr_count", 32'(wa_log.size()), 32'd0);
`else
        check("b2_latency", 32'(lat), 32'd24);
        check("b2_wr_count", 32'(wa_log.size()), 32'd8);
`endif
        check("b2_bitmap", 32'(rsp_bitmap), 32'h6633);
        check("b2_scanline", 32'(rsp_scanline), 32'h0);
        ack();

        // B with only attr[24] cleared.
        do_req(4'hF, 6'h01, 16'hA5C3, 25'h003C0F, lat);
`ifdef STYLER_HOST_DIFF_EN
        check("b3_latency", 32'(lat), 32'd10);
        check("b3_wr_count", 32'(wa_log.size()), 32'd1);
        check("b3_wr_addr", 32'(wa_log[0]), 32'd7);
        check("b3_wr_data", 32'(wd_log[0]), 32'd0);
`else
        check("b3_latency", 32'(lat), 32'd24);
        check("b3_wr_count", 32'(wa_log.size()), 32'd8);
        check("b3_wr_data7", 32'(wd_log[7]), 32'd0);
`endif
        check("b3_bitmap", 32'(rsp_bitmap), 32'h6633);
        ack();

        // Reset in cycle 5 of A's write sequence.
        req_scanline = 4'd5;
        req_ctrl     = 6'h00;
        req_bitmap   = 16'h1234;
        req_attr     = 25'h0;
        req_valid    = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("mid_in_write", 32'(st_uio_oe), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_st_ui", 32'(st_ui), 32'h98);
        check("mid_rst_oe", 32'(st_uio_oe), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();

        do_req(4'd5, 6'h00, 16'h1234, 25'h0, lat);
        check("a2_latency", 32'(lat), 32'd24);
        check_writes(a_bytes);
        check("a2_bitmap", 32'(rsp_bitmap), 32'h1234);
        check("a2_scanline", 32'(rsp_scanline), 32'h6);
        ack();

        // READ_WAIT = 3 instance, same request.
        check("rw3_req_ready", 32'(req_ready3), 32'd1);
        req_scanline = 4'd5;
        req_ctrl     = 6'h00;
        req_bitmap   = 16'h1234;
        req_attr     = 25'h0;
        req_valid3   = 1'b1;
        tick();
        req_valid3 = 1'b0;
        req_bitmap = 16'hFFFF;
        lat = 1;
        while (!rsp_valid3 && lat < 200) begin
            tick();
            lat++;
        end
        check("rw3_latency", 32'(lat), 32'd30);
        check("rw3_bitmap", 32'(rsp_bitmap3), 32'h1234);
        check("rw3_scanline", 32'(rsp_scanline3), 32'h6);
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        check("rw3_rsp_valid_drop", 32'(rsp_valid3), 32'd0);

        check("bus_rule_viol", 32'(bus_viol), 32'd0);
        check("phase_viol", 32'(ph_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
